// File: rtl/stp_key_var_if.sv
// stp_key_var_if: key-word stream in, assembled key and status out
interface stp_key_var_if #(
    parameter int IN_W = 8
);
    logic              start;
    logic [1:0]        key_len;
    logic [IN_W-1:0]   a;
    logic              a_valid;
    logic [255:0]      z;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (output start, key_len, a, a_valid, input z, ready, busy, err);
    modport slave  (input start, key_len, a, a_valid, output z, ready, busy, err);
endinterface

// File: rtl/stp_key_var.sv
// stp_key_var: assembles a 128/192/256-bit AES key from a stream of IN_W-bit words
module stp_key_var #(
    parameter int IN_W     = 8,
    parameter int MAX_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    stp_key_var_if.slave bus
);
    localparam int CW = $clog2(256 / IN_W + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       n;
    logic [CW-1:0]       n_sel;
    logic [MAX_BITS-1:0] kbuf;
    logic [MAX_BITS-1:0] merged;
    logic [MAX_BITS-1:0] z_q;
    logic [8:0]          sh;
    logic                ready_q;
    logic                busy_q;
    logic                err_q;
    logic                accept;
    logic                bad;
    logic                take;
    logic                last;

    assign bus.z     = z_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

    // Decode start, word target and the buffer image with the current word merged in
    always_comb begin
        accept = bus.start && bus.key_len != 2'b11;
        bad    = bus.start && bus.key_len == 2'b11;
        take   = state == LOAD && bus.a_valid && !accept;
        last   = cnt == n - CW'(1);
        sh     = 9'(cnt) * 9'(IN_W);
        merged = kbuf | ({bus.a, {(MAX_BITS - IN_W){1'b0}}} >> sh);
        n_sel  = bus.key_len == 2'b00 ? CW'(128 / IN_W) :
                 bus.key_len == 2'b01 ? CW'(192 / IN_W) : CW'(256 / IN_W);
    end

    // Load FSM: a legal start (re)starts a load, words fill MSB-first, last word publishes z
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            n       <= '0;
            kbuf    <= '0;
            z_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bad || (accept && state == LOAD);
            if (accept) begin
                state   <= LOAD;
                n       <= n_sel;
                cnt     <= '0;
                kbuf    <= '0;
                z_q     <= '0;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
            end else if (take) begin
                kbuf <= merged;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    z_q     <= merged;
                    state   <= DONE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            end
        end
    end
endmodule
